accum_seq_proc: RTL and testbench
=================================

# accum_seq_proc

Parametrised dedicated processor that sums an arithmetic sequence 0, S, 2S, … of all terms below a runtime limit L. A controller FSM drives an index/accumulator datapath; a start/done handshake frames each run. It is the generalised successor of the fixed 8-bit "sum 0..9" processor. Width, limit, step and overflow policy are configurable. The final sum is held on a registered result port.

## Interface
Parameters:
- WIDTH, 8: accumulator and result width in bits.
- CNT_WIDTH, 8: index, limit and step width in bits.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a run; sampled only in IDLE.
- limit  in  CNT_WIDTH  exclusive upper bound L; latched on accepted start.
- step  in  CNT_WIDTH  index increment S; latched on accepted start; 0 is latched as 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, high only in DONE.
- result  out  WIDTH  final sum of the last completed run.
- ovf  out  1  sticky accumulator overflow flag of the last completed run.

## Operation
- Registers:
  - i (CNT_WIDTH): index.
  - acc (WIDTH): accumulator.
  - ovf_r: internal overflow flag.
  - limit_q, step_q: latched limit and step.
  - result, ovf: outputs.
- FSM is Moore, with states IDLE, INIT, CMP, ADD, DONE.
- IDLE:
  - If start=1, latch limit_q=limit and step_q=(step==0 ? 1 : step); go to INIT.
  - Otherwise stay in IDLE.
- INIT: i<=0, acc<=0, ovf_r<=0; go to CMP.
- CMP:
  - If i < limit_q (unsigned), go to ADD.
  - Otherwise result<=acc, ovf<=ovf_r, and go to DONE.
- ADD:
  - acc <= acc + zero-extended i, computed in WIDTH+1 bits. A carry sets ovf_r (sticky).
  - Index update: i <= i + step_q, computed in CNT_WIDTH+1 bits.
  - If the index sum carries, i <= limit_q (the next CMP then terminates). The run never loops forever.
  - Go to CMP.
- DONE: done=1; go to IDLE.
- start while busy is ignored (no queuing). start held high re-triggers from IDLE on the cycle after DONE.
- result and ovf change only on the edge entering DONE. They stay stable from that point through the next run.

## Timing
- Reset values:
  - state=IDLE.
  - busy=0, done=0, result=0, ovf=0.
  - i=0, acc=0, limit_q=0, step_q=1.
- Let N = number of terms = ceil(L/S) (0 if L=0). Cycle 0 is the edge where start is sampled in IDLE.
- State sequence: INIT at cycle 1; CMP at 2+2k; ADD at 3+2k (k = 0..N-1); DONE at cycle 3+2N; IDLE at 4+2N.
- result and ovf are valid in the DONE cycle, i.e. coincident with done.
- busy goes high at cycle 1 and low at cycle 4+2N.
- rst mid-run: immediate return to IDLE with all reset values. No done pulse is emitted, and the prior result is cleared to 0.

## Configuration
- Macro: ACCUM_SATURATE_EN.
- Defined: on accumulator carry, acc clamps to all-ones (2^WIDTH-1) and ovf_r is set. Later additions keep acc at all-ones.
- Undefined: acc wraps modulo 2^WIDTH and ovf_r is set on each carry (sticky).
- Handshake, latency and index behaviour are identical in both builds.

## Test plan
- L=10, S=1, defaults: result=45, ovf=0; done high exactly at cycle 23, single cycle; busy high for cycles 1..23.
- L=0: no ADD states; done at cycle 3, result=0. Then L=10, S=3: terms 0,3,6,9, result=18, done at cycle 11.
- WIDTH=8, L=30, S=1 (true sum 435): without macro result=179, ovf=1. With ACCUM_SATURATE_EN result=255, ovf=1.
- Index wrap, CNT_WIDTH=8, L=255, S=200: terms 0,200; the carry terminates the run; result=200, ovf=0, done at cycle 7. Separately, S=0 with L=4 behaves as S=1: result=6.
- start pulsed during ADD of a run is ignored. Exactly one done per accepted start. result holds 45 through the following run until its DONE.
- rst asserted at cycle 10 of an L=10 run: outputs reset asynchronously and no done pulse occurs. A new start after release yields result=45 at cycle 23 relative to that start.

Source files
------------

// File: rtl/accum_seq_proc.sv
// Sums the arithmetic sequence 0, S, 2S, ... of all terms below a runtime limit L.
// Latency: 4 + 2*ceil(L/S) cycles from accepted start to the return to IDLE; done pulses one cycle earlier.
// No backpressure: start is sampled only in IDLE and is ignored while busy (no queuing).
// Build option: define ACCUM_SATURATE_EN to clamp the accumulator at all-ones instead of wrapping.
module accum_seq_proc #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] limit,
    input  logic [CNT_WIDTH-1:0] step,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 ovf
);

    // Sum width large enough for both operands plus a carry bit
    localparam int SW = ((WIDTH > CNT_WIDTH) ? WIDTH : CNT_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_CMP  = 3'd2,
        S_ADD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_WIDTH-1:0] r_i;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_ovf;
    logic [CNT_WIDTH-1:0] r_limit_q;
    logic [CNT_WIDTH-1:0] r_step_q;
    logic [WIDTH-1:0]     r_result;
    logic                 r_ovf_out;

    logic                 w_lt;
    logic [SW-1:0]        w_acc_sum;
    logic                 w_acc_carry;
    logic [WIDTH-1:0]     w_acc_next;
    logic [CNT_WIDTH:0]   w_i_sum;

    // Compare, accumulate and index-advance arithmetic
    always_comb begin
        w_lt        = (r_i < r_limit_q);
        w_acc_sum   = SW'(r_acc) + SW'(r_i);
        w_acc_carry = |w_acc_sum[SW-1:WIDTH];
`ifdef ACCUM_SATURATE_EN
        w_acc_next  = w_acc_carry ? {WIDTH{1'b1}} : w_acc_sum[WIDTH-1:0];
`else
        w_acc_next  = w_acc_sum[WIDTH-1:0];
`endif
        w_i_sum     = {1'b0, r_i} + {1'b0, r_step_q};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_INIT;
            end
            S_INIT: w_next = S_CMP;
            S_CMP:  w_next = w_lt ? S_ADD : S_DONE;
            S_ADD:  w_next = S_CMP;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands, iterate, and capture the final sum on the way into DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i       <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_limit_q <= '0;
            r_step_q  <= CNT_WIDTH'(1);
            r_result  <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_limit_q <= limit;
                        // A zero step would never terminate; treat it as one
                        r_step_q  <= (step == '0) ? CNT_WIDTH'(1) : step;
                    end
                end
                S_INIT: begin
                    r_i   <= '0;
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end
                S_CMP: begin
                    if (!w_lt) begin
                        r_result  <= r_acc;
                        r_ovf_out <= r_ovf;
                    end
                end
                S_ADD: begin
                    r_acc <= w_acc_next;
                    if (w_acc_carry) r_ovf <= 1'b1;
                    // An index carry means every further term is past the limit
                    r_i   <= w_i_sum[CNT_WIDTH] ? r_limit_q : w_i_sum[CNT_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign ovf    = r_ovf_out;

endmodule

// File: tb/tb_accum_seq_proc.sv
// Randomized and directed bench for accum_seq_proc against a plain-arithmetic reference.
// Cycle numbering: cycle 0 ends at the edge sampling start; outputs of cycle c are sampled at the negedge after edge c-1.
// Inputs are driven on negedges; start noise is injected only while the DUT is busy.
module tb_accum_seq_proc;

    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [CNT_WIDTH-1:0] limit;
    logic [CNT_WIDTH-1:0] step;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 ovf;

    int n_tests;
    int n_fail;
    longint prev_res;
    longint prev_ovf;

    accum_seq_proc #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .limit  (limit),
        .step   (step),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One run from start to the return to IDLE, checking every cycle
    task automatic run(input int lim, input int stp, input bit noise);
        int     s_eff;
        int     n;
        longint sum;
        longint exp_res;
        longint exp_ovf;
        int     last;
        int     n_done;
        s_eff = (stp == 0) ? 1 : stp;
        sum   = 0;
        n     = 0;
        for (longint t = 0; t < lim; t += s_eff) begin
            sum += t;
            n++;
        end
        exp_ovf = (sum >= (64'd1 << WIDTH)) ? 1 : 0;
`ifdef ACCUM_SATURATE_EN
        exp_res = exp_ovf ? ((64'd1 << WIDTH) - 1) : sum;
`else
        exp_res = sum % (64'd1 << WIDTH);
`endif
        last   = 4 + 2 * n;
        n_done = 0;
        @(negedge clk);
        limit = CNT_WIDTH'(lim);
        step  = CNT_WIDTH'(stp);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (done) n_done++;
            chk($sformatf("busy c%0d", c), longint'(busy), (c < last) ? 1 : 0);
            chk($sformatf("done c%0d", c), longint'(done), (c == last - 1) ? 1 : 0);
            chk($sformatf("result c%0d", c), longint'(result), (c < last - 1) ? prev_res : exp_res);
            chk($sformatf("ovf c%0d", c), longint'(ovf), (c < last - 1) ? prev_ovf : exp_ovf);
            if (noise && c < last - 1) begin
                start = 1'($urandom_range(0, 1));
                limit = CNT_WIDTH'($urandom);
                step  = CNT_WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk("done count", longint'(n_done), 1);
        prev_res = exp_res;
        prev_ovf = exp_ovf;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        prev_res = 0;
        prev_ovf = 0;
        rst   = 1'b1;
        start = 1'b0;
        limit = '0;
        step  = '0;
        #12;
        chk("rst busy", longint'(busy), 0);
        chk("rst done", longint'(done), 0);
        chk("rst result", longint'(result), 0);
        chk("rst ovf", longint'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(10, 1, 1'b0);
        chk("sum0..9", longint'(result), 45);
        run(0, 5, 1'b0);
        run(10, 3, 1'b0);
        run(30, 1, 1'b0);
        run(255, 200, 1'b0);
        run(4, 0, 1'b0);
        chk("step0 as 1", longint'(result), 6);
        run(10, 1, 1'b1);
        run(20, 2, 1'b1);

        for (int r = 0; r < 15; r++) begin
            int l;
            int s;
            l = $urandom_range(0, 255);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            run(l, s, 1'b1);
        end

        // Abort an L=10 run at cycle 10 with an asynchronous reset
        @(negedge clk);
        limit = 8'd10;
        step  = 8'd1;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("pre-rst done c%0d", c), longint'(done), 0);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst busy", longint'(busy), 0);
        chk("mid rst done", longint'(done), 0);
        chk("mid rst result", longint'(result), 0);
        chk("mid rst ovf", longint'(ovf), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("held rst done", longint'(done), 0);
        end
        rst      = 1'b0;
        prev_res = 0;
        prev_ovf = 0;
        run(10, 1, 1'b0);
        chk("post rst sum", longint'(result), 45);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
